lzc_normalizer: RTL and testbench

Parametrised, pipelined leading-zero counter and normalising left-shifter for the adder's post-addition normalisation path. It accepts a W-bit magnitude and a shift limit, which is the headroom the exponent can absorb. After two registered stages it returns the leading-zero count, the applied shift and the normalised magnitude. Ready/valid handshaking on both sides lets it sit between the mantissa add stage and the rounding stage under back-pressure.

---
 rtl/lzc_normalizer_if.sv | 29 ++
 rtl/lzc_normalizer.sv | 134 +++++++++++++
 tb/tb_lzc_normalizer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lzc_normalizer_if.sv
// Ready/valid bundle between the mantissa add stage, the normaliser and the rounder.
// The master drives the word and accepts results; the slave is the normaliser itself.
interface lzc_normalizer_if #(
  parameter int W  = 28,
  parameter int LW = 8,
  parameter int CW = $clog2(W + 1)
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_mag;
  logic [LW-1:0] in_limit;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_lzc;
  logic [CW-1:0] out_shift;
  logic [W-1:0]  out_mag;
  logic          out_zero;
  logic          out_clamped;

  modport master (
    output in_valid, in_mag, in_limit, out_ready,
    input  in_ready, out_valid, out_lzc, out_shift, out_mag, out_zero, out_clamped
  );

  modport slave (
    input  in_valid, in_mag, in_limit, out_ready,
    output in_ready, out_valid, out_lzc, out_shift, out_mag, out_zero, out_clamped
  );
endinterface

// File: rtl/lzc_normalizer.sv
// Two-stage leading-zero counter and limited normalising left shifter.
// Stage 1 counts and clamps the shift, stage 2 shifts; one global stall freezes both.
module lzc_normalizer #(
  parameter int W  = 28,
  parameter int LW = 8
) (
  input logic             clk,
  input logic             rst,
  lzc_normalizer_if.slave bus
);

  localparam int CW = $clog2(W + 1);
  localparam int MW = (LW > CW) ? LW : CW;
  localparam int P  = 1 << $clog2(W);
  localparam int TW = $clog2(P) + 1;

  // Padding the LSB side with ones makes the all-zero input count exactly W.
  function automatic logic [CW-1:0] lzc_tree(input logic [W-1:0] v);
    logic [P-1:0]  x;
    logic [TW-1:0] c [P];
    x = {P{1'b1}};
    x[P-1 -: W] = v;
    for (int i = 0; i < P; i++) begin
      c[i] = {{(TW-1){1'b0}}, ~x[P-1-i]};
    end
    for (int s = 1; s < P; s = s * 2) begin
      for (int i = 0; i < P; i = i + 2 * s) begin
        if (c[i] == TW'(s)) begin
          c[i] = TW'(s) + c[i+s];
        end else begin
          c[i] = c[i];
        end
      end
    end
    return CW'(c[0]);
  endfunction

  function automatic logic [W-1:0] shl(input logic [W-1:0] v, input logic [CW-1:0] sh);
    logic [W-1:0] m;
    m = v;
    for (int b = 0; b < CW; b++) begin
      if (sh[b]) begin
        m = m << (1 << b);
      end else begin
        m = m;
      end
    end
    return m;
  endfunction

  logic          s1_valid_r;
  logic [W-1:0]  s1_mag_r;
  logic [CW-1:0] s1_lzc_r;
  logic [CW-1:0] s1_shift_r;
  logic          s1_zero_r;
  logic          s1_clamped_r;

  logic          out_valid_r;
  logic [W-1:0]  out_mag_r;
  logic [CW-1:0] out_lzc_r;
  logic [CW-1:0] out_shift_r;
  logic          out_zero_r;
  logic          out_clamped_r;

  logic          stall_s;
  logic [CW-1:0] lzc_s;
  logic [CW-1:0] shift_s;
  logic [MW-1:0] limit_x_s;
  logic [MW-1:0] lzc_x_s;
  logic          clamped_s;
  logic          zero_s;
  logic [W-1:0]  s2_mag_s;

  assign stall_s      = out_valid_r & ~bus.out_ready;
  assign bus.in_ready = ~stall_s;

  // Stage 1 combinational: count, then clamp the shift to the exponent headroom.
  always_comb begin
    lzc_s     = lzc_tree(bus.in_mag);
    limit_x_s = MW'(bus.in_limit);
    lzc_x_s   = MW'(lzc_s);
    clamped_s = (limit_x_s < lzc_x_s);
    zero_s    = ~|bus.in_mag;
    if (clamped_s) begin
      shift_s = CW'(limit_x_s);
    end else begin
      shift_s = lzc_s;
    end
  end

  // Stage 2 combinational: barrel shift of the held stage-1 magnitude.
  always_comb begin
    s2_mag_s = shl(s1_mag_r, s1_shift_r);
  end

  // Pipeline registers; both stages advance together unless the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r    <= 1'b0;
      s1_mag_r      <= {W{1'b0}};
      s1_lzc_r      <= {CW{1'b0}};
      s1_shift_r    <= {CW{1'b0}};
      s1_zero_r     <= 1'b0;
      s1_clamped_r  <= 1'b0;
      out_valid_r   <= 1'b0;
      out_mag_r     <= {W{1'b0}};
      out_lzc_r     <= {CW{1'b0}};
      out_shift_r   <= {CW{1'b0}};
      out_zero_r    <= 1'b0;
      out_clamped_r <= 1'b0;
    end else if (!stall_s) begin
      s1_valid_r    <= bus.in_valid;
      s1_mag_r      <= bus.in_mag;
      s1_lzc_r      <= lzc_s;
      s1_shift_r    <= shift_s;
      s1_zero_r     <= zero_s;
      s1_clamped_r  <= clamped_s;
      out_valid_r   <= s1_valid_r;
      out_mag_r     <= s2_mag_s;
      out_lzc_r     <= s1_lzc_r;
      out_shift_r   <= s1_shift_r;
      out_zero_r    <= s1_zero_r;
      out_clamped_r <= s1_clamped_r;
    end
  end

  assign bus.out_valid   = out_valid_r;
  assign bus.out_mag     = out_mag_r;
  assign bus.out_lzc     = out_lzc_r;
  assign bus.out_shift   = out_shift_r;
  assign bus.out_zero    = out_zero_r;
  assign bus.out_clamped = out_clamped_r;

endmodule

// File: tb/tb_lzc_normalizer.sv
// Bench for lzc_normalizer: directed literal cases on a W=28 instance, a scoreboard
// model checked every cycle, and a width sweep (2, 8, 24, 28, 53) fed from one source.
module tb_lzc_normalizer;

  localparam int W  = 28;
  localparam int LW = 8;
  localparam int NS = 5;

  function automatic int sw_width(input int k);
    case (k)
      0:       return 2;
      1:       return 8;
      2:       return 24;
      3:       return 28;
      default: return 53;
    endcase
  endfunction

  typedef struct {
    logic [63:0] mag;
    int          lzc;
    int          shift;
    logic        zero;
    logic        clamped;
  } res_t;

  // Reference: lzc is width minus the bit length of the value.
  function automatic res_t model(input int w, input logic [63:0] mag, input int lim);
    res_t        r;
    logic [63:0] mask;
    logic [63:0] m;
    int          len;
    mask = (64'd1 << w) - 64'd1;
    m    = mag & mask;
    len  = 0;
    while (len < 64 && (m >> len) != 64'd0) len++;
    r.lzc     = w - len;
    r.zero    = (m == 64'd0);
    r.clamped = (lim < r.lzc);
    r.shift   = r.clamped ? lim : r.lzc;
    r.mag     = (m << r.shift) & mask;
    return r;
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lzc_normalizer_if #(.W(W), .LW(LW)) bus ();
  lzc_normalizer #(.W(W), .LW(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic        sw_valid;
  logic [63:0] sw_mag;
  logic [7:0]  sw_limit;
  logic        sw_ovalid [NS];
  logic        sw_iready [NS];
  logic [63:0] sw_omag   [NS];
  logic [7:0]  sw_olzc   [NS];
  logic [7:0]  sw_oshift [NS];
  logic        sw_ozero  [NS];
  logic        sw_oclamp [NS];

  for (genvar k = 0; k < NS; k++) begin : g_sw
    localparam int SW = sw_width(k);
    lzc_normalizer_if #(.W(SW), .LW(8)) sif ();
    lzc_normalizer #(.W(SW), .LW(8)) u_dut (.clk(clk), .rst(rst), .bus(sif));
    assign sif.in_valid  = sw_valid;
    assign sif.in_mag    = sw_mag[SW-1:0];
    assign sif.in_limit  = sw_limit;
    assign sif.out_ready = 1'b1;
    assign sw_ovalid[k]  = sif.out_valid;
    assign sw_iready[k]  = sif.in_ready;
    assign sw_omag[k]    = 64'(sif.out_mag);
    assign sw_olzc[k]    = 8'(sif.out_lzc);
    assign sw_oshift[k]  = 8'(sif.out_shift);
    assign sw_ozero[k]   = sif.out_zero;
    assign sw_oclamp[k]  = sif.out_clamped;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  res_t        exp_q[$];
  logic        prev_rst   = 1'b1;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_mag;
  logic [7:0]  prev_lzc, prev_shift;
  logic        prev_zero, prev_clamp;
  logic        h_valid [2];
  logic [63:0] h_mag   [2];
  int          h_lim   [2];

  // Compare process: scoreboard for the main instance, two-deep history for the sweep.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      exp_q.delete();
      h_valid[0] = 1'b0;
      h_valid[1] = 1'b0;
    end else begin
      chk("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
      if (prev_stall && !prev_rst) begin
        chk("stall hold valid", 64'(bus.out_valid), 64'd1);
        chk("stall hold mag", 64'(bus.out_mag), prev_mag);
        chk("stall hold lzc", 64'(bus.out_lzc), 64'(prev_lzc));
        chk("stall hold shift", 64'(bus.out_shift), 64'(prev_shift));
        chk("stall hold flags", 64'({bus.out_zero, bus.out_clamped}), 64'({prev_zero, prev_clamp}));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected output", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb mag", 64'(bus.out_mag), e.mag);
          chk("sb lzc", 64'(bus.out_lzc), 64'(e.lzc));
          chk("sb shift", 64'(bus.out_shift), 64'(e.shift));
          chk("sb zero", 64'(bus.out_zero), 64'(e.zero));
          chk("sb clamped", 64'(bus.out_clamped), 64'(e.clamped));
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(W, 64'(bus.in_mag), int'(bus.in_limit)));

      for (int k = 0; k < NS; k++) begin
        chk($sformatf("sw%0d in_ready", sw_width(k)), 64'(sw_iready[k]), 64'd1);
        chk($sformatf("sw%0d valid", sw_width(k)), 64'(sw_ovalid[k]), 64'(h_valid[1]));
        if (h_valid[1]) begin
          e = model(sw_width(k), h_mag[1], h_lim[1]);
          chk($sformatf("sw%0d mag in=0x%0h lim=%0d", sw_width(k), h_mag[1], h_lim[1]), sw_omag[k], e.mag);
          chk($sformatf("sw%0d lzc in=0x%0h", sw_width(k), h_mag[1]), 64'(sw_olzc[k]), 64'(e.lzc));
          chk($sformatf("sw%0d shift in=0x%0h lim=%0d", sw_width(k), h_mag[1], h_lim[1]), 64'(sw_oshift[k]), 64'(e.shift));
          chk($sformatf("sw%0d zero", sw_width(k)), 64'(sw_ozero[k]), 64'(e.zero));
          chk($sformatf("sw%0d clamped lim=%0d", sw_width(k), h_lim[1]), 64'(sw_oclamp[k]), 64'(e.clamped));
        end
      end
      h_valid[1] = h_valid[0];
      h_mag[1]   = h_mag[0];
      h_lim[1]   = h_lim[0];
      h_valid[0] = sw_valid;
      h_mag[0]   = sw_mag;
      h_lim[0]   = int'(sw_limit);
    end
    prev_rst   = rst;
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_mag   = 64'(bus.out_mag);
    prev_lzc   = 8'(bus.out_lzc);
    prev_shift = 8'(bus.out_shift);
    prev_zero  = bus.out_zero;
    prev_clamp = bus.out_clamped;
  end

  task automatic directed(input string name, input logic [27:0] mag, input logic [7:0] lim,
                          input int e_lzc, input int e_shift, input logic [27:0] e_mag,
                          input logic e_zero, input logic e_clamp);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_mag   = mag;
    bus.in_limit = lim;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({name, " valid early"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk({name, " valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, " lzc"}, 64'(bus.out_lzc), 64'(e_lzc));
    chk({name, " shift"}, 64'(bus.out_shift), 64'(e_shift));
    chk({name, " mag"}, 64'(bus.out_mag), 64'(e_mag));
    chk({name, " zero"}, 64'(bus.out_zero), 64'(e_zero));
    chk({name, " clamped"}, 64'(bus.out_clamped), 64'(e_clamp));
  endtask

  task automatic check_reset_state(input string name);
    chk({name, " out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({name, " out_lzc"}, 64'(bus.out_lzc), 64'd0);
    chk({name, " out_shift"}, 64'(bus.out_shift), 64'd0);
    chk({name, " out_mag"}, 64'(bus.out_mag), 64'd0);
    chk({name, " flags"}, 64'({bus.out_zero, bus.out_clamped}), 64'd0);
    chk({name, " in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   tries;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_mag = '0; bus.in_limit = '0; bus.out_ready = 1'b1;
    sw_valid = 1'b0; sw_mag = 64'd0; sw_limit = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    directed("msb", 28'h8000000, 8'hFF, 0, 0, 28'h8000000, 1'b0, 1'b0);
    directed("lsb", 28'h0000001, 8'hFF, 27, 27, 28'h8000000, 1'b0, 1'b0);
    directed("mid", 28'h0123456, 8'hFF, 7, 7, 28'h91A2B00, 1'b0, 1'b0);
    directed("zero ff", 28'h0000000, 8'hFF, 28, 28, 28'h0000000, 1'b1, 1'b0);
    directed("zero 5", 28'h0000000, 8'd5, 28, 5, 28'h0000000, 1'b1, 1'b1);
    directed("zero 28", 28'h0000000, 8'd28, 28, 28, 28'h0000000, 1'b1, 1'b0);
    directed("clamp 10", 28'h0000001, 8'd10, 27, 10, 28'h0000400, 1'b0, 1'b1);
    directed("limit eq", 28'h0000001, 8'd27, 27, 27, 28'h8000000, 1'b0, 1'b0);

    // Back-pressure: 8 words, output blocked for 3 cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          @(posedge clk); #1;
          bus.in_valid = 1'b1;
          bus.in_mag   = 28'($urandom) >> $urandom_range(0, 27);
          bus.in_limit = 8'($urandom_range(0, 40));
          tries = 0;
          do begin
            @(negedge clk);
            acc = bus.in_ready;
            tries++;
          end while (!acc && tries < 50);
          if (!acc) chk("bp accept timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp in_ready low", 64'(bus.in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    #1 chk("bp drained", 64'(exp_q.size()), 64'd0);

    // Reset with two words in flight; neither may ever be delivered.
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_mag = 28'h0123456; bus.in_limit = 8'hFF;
    @(posedge clk); #1;
    bus.in_mag = 28'h0000001; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    check_reset_state("mid reset");
    repeat (4) begin
      @(negedge clk);
      chk("after reset valid", 64'(bus.out_valid), 64'd0);
    end

    // Width sweep: every single-bit input, then random words and limits.
    for (int b = 0; b < 53; b++) begin
      @(posedge clk); #1;
      sw_valid = 1'b1;
      sw_mag   = 64'd1 << b;
      sw_limit = (b % 3 == 0) ? 8'hFF : 8'($urandom_range(0, 60));
    end
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      sw_mag   = {$urandom, $urandom} >> $urandom_range(0, 63);
      sw_limit = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 56));
    end
    @(posedge clk); #1;
    sw_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("final queue empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
